// File: rtl/cnn_fetch_pkg.sv
// Shared constants and state encoding for the CNN pixel fetch engine.
package cnn_fetch_pkg;

    localparam int unsigned BYTES_PER_WORD    = 4;
    localparam int unsigned BYTE_CNT_W        = 3;
    localparam int unsigned DEFAULT_LEN_WIDTH = 16;
    localparam int unsigned STATE_W           = 3;

    typedef logic [STATE_W-1:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 3'd0;
    localparam fetch_state_t ST_REQ   = 3'd1;
    localparam fetch_state_t ST_WAIT  = 3'd2;
    localparam fetch_state_t ST_DRAIN = 3'd3;
    localparam fetch_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/obi_pkg.sv
// Minimal OBI bus configuration and channel types used by the fetch block and its bench.
package obi_pkg;

    localparam int unsigned OBI_ADDR_W = 32;
    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = OBI_DATA_W / 8;
    localparam int unsigned OBI_ID_W   = 1;

    typedef struct packed {
        int unsigned addr_width;
        int unsigned data_width;
        int unsigned id_width;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{
        addr_width: OBI_ADDR_W,
        data_width: OBI_DATA_W,
        id_width:   OBI_ID_W
    };

    typedef struct packed {
        logic [OBI_ADDR_W-1:0] addr;
        logic                  we;
        logic [OBI_BE_W-1:0]   be;
        logic [OBI_DATA_W-1:0] wdata;
        logic [OBI_ID_W-1:0]   aid;
        logic [0:0]            a_optional;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
    } obi_req_t;

    typedef struct packed {
        logic [OBI_DATA_W-1:0] rdata;
        logic [OBI_ID_W-1:0]   rid;
        logic                  err;
        logic [0:0]            r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;

endpackage

// File: rtl/cnn_word_unpacker.sv
// Serialises one 32-bit word into up to four little-endian bytes over a ready/valid port.
module cnn_word_unpacker
    import cnn_fetch_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [31:0]           word_i,
    input  logic [BYTE_CNT_W-1:0] count_i,
    output logic [7:0]            pixel_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_c
);

    logic [31:0]           word_q;
    logic [BYTE_CNT_W-1:0] cnt_q;
    logic                  valid_q;
    logic                  hs_c;

    assign hs_c    = valid_q & ready_i;
    assign last_c  = hs_c & (cnt_q == BYTE_CNT_W'(1));
    assign pixel_o = word_q[7:0];
    assign valid_o = valid_q;

    // Current byte always sits in the low lane; shift down on each accepted byte.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            word_q  <= word_i;
            cnt_q   <= count_i;
            valid_q <= (count_i != '0);
        end else if (hs_c) begin
            word_q  <= last_c ? '0 : {8'h00, word_q[31:8]};
            cnt_q   <= cnt_q - BYTE_CNT_W'(1);
            valid_q <= ~last_c;
        end
    end

endmodule

// File: rtl/cnn_obi_fetch.sv
// OBI read engine: fetches a run of 8-bit pixels word by word and streams them to the line buffer.
module cnn_obi_fetch
    import cnn_fetch_pkg::*;
#(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
    parameter int unsigned       LEN_WIDTH = DEFAULT_LEN_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [LEN_WIDTH-1:0] num_pixels_i,
    output obi_req_t             obi_req_o,
    input  obi_rsp_t             obi_rsp_i,
    output logic [7:0]           pixel_o,
    output logic                 pixel_valid_o,
    input  logic                 pixel_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned AddrW = ObiCfg.addr_width;

    fetch_state_t          state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  err_q, err_d;
    logic                  req_q, busy_q, done_q;
    logic                  load_c, last_c, pix_hs_c;
    logic [BYTE_CNT_W-1:0] byte_cnt_c;
    logic                  unused_c;

    assign unused_c = ^{base_addr_i[1:0], obi_rsp_i.r.rid, obi_rsp_i.r.r_optional};

    assign pix_hs_c   = pixel_valid_o & pixel_ready_i;
    assign byte_cnt_c = (rem_q >= LEN_WIDTH'(BYTES_PER_WORD)) ? BYTE_CNT_W'(BYTES_PER_WORD)
                                                              : BYTE_CNT_W'(rem_q);

    // Next-state logic: one outstanding read, then drain its bytes before the next request.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        load_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (num_pixels_i != '0) begin
                        addr_d  = {base_addr_i[31:2], 2'b00};
                        rem_d   = num_pixels_i;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (obi_rsp_i.gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (obi_rsp_i.rvalid) begin
                    if (obi_rsp_i.r.err) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        load_c  = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pix_hs_c) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                end
                if (last_c) begin
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            req_q   <= (state_d == ST_REQ);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Address phase is read-only, full-word; all fields come straight from flops or constants.
    always_comb begin
        obi_req_o         = '0;
        obi_req_o.req     = req_q;
        obi_req_o.a.addr  = AddrW'(addr_q);
        obi_req_o.a.we    = 1'b0;
        obi_req_o.a.be    = 4'hF;
        obi_req_o.a.wdata = '0;
        obi_req_o.a.aid   = '0;
        obi_req_o.a.a_optional = '0;
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    cnn_word_unpacker u_unpacker (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (load_c),
        .word_i  (obi_rsp_i.r.rdata),
        .count_i (byte_cnt_c),
        .pixel_o (pixel_o),
        .valid_o (pixel_valid_o),
        .ready_i (pixel_ready_i),
        .last_c  (last_c)
    );

endmodule

// File: tb/tb_cnn_obi_fetch.sv
// Bench for cnn_obi_fetch: job table with an OBI memory responder and a pixel scoreboard.
module tb_cnn_obi_fetch;
    import obi_pkg::*;

    localparam int unsigned LW = 16;

    typedef struct {
        logic [31:0] base;
        int          len;
        int          gnt_delay;
        bit          rand_ready;
        int          err_at;
        bit          restart;
        int          exp_reads;
        bit          exp_err;
    } job_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   base = '0;
    logic [LW-1:0] npix = '0;
    obi_req_t      obi_req;
    obi_rsp_t      obi_rsp;
    logic [7:0]    pixel;
    logic          pixel_valid;
    logic          pixel_ready;
    logic          busy, done, err;

    int total = 0;
    int bad = 0;
    int gnt_delay = 0;
    int err_at = -1;
    int rd_idx = 0;
    int reads_seen = 0;
    int done_cnt = 0;
    bit rand_ready = 1'b0;
    bit drop_rsp = 1'b0;
    bit inj_rvalid = 1'b0;
    logic [31:0] exp_addr[$];
    logic [7:0]  exp_pix[$];
    job_t jobs[9];

    always #5 clk = ~clk;

    cnn_obi_fetch #(
        .ObiCfg    (ObiDefaultConfig),
        .obi_req_t (obi_req_t),
        .obi_rsp_t (obi_rsp_t),
        .LEN_WIDTH (LW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .base_addr_i   (base),
        .num_pixels_i  (npix),
        .obi_req_o     (obi_req),
        .obi_rsp_i     (obi_rsp),
        .pixel_o       (pixel),
        .pixel_valid_o (pixel_valid),
        .pixel_ready_i (pixel_ready),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h4433_2211;
            32'h0000_1004: return 32'h8877_6655;
            default:       return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1357};
        endcase
    endfunction

    // OBI subordinate: programmable grant delay, one-cycle read latency, optional error word.
    initial begin : responder
        int stall;
        bit pend, rv_ok, req_wait;
        logic [31:0] paddr, req_addr;
        stall = 0; pend = 0; rv_ok = 0; req_wait = 0; paddr = '0; req_addr = '0;
        obi_rsp = '0;
        forever begin
            @(posedge clk); #1;
            if (rv_ok) chk("pix_latency", 32'(pixel_valid), 32'd1);
            rv_ok = 0;
            if (req_wait) begin
                chk("req_hold", 32'(obi_req.req), 32'd1);
                chk("addr_hold", obi_req.a.addr, req_addr);
            end
            req_wait = 0;
            obi_rsp = '0;
            if (!rst_n) begin
                stall = 0; pend = 0;
                continue;
            end
            if (pend) begin
                obi_rsp.rvalid  = 1'b1;
                obi_rsp.r.rdata = mem_rd(paddr);
                obi_rsp.r.err   = (rd_idx == err_at);
                rv_ok = !obi_rsp.r.err;
                rd_idx++;
                pend = 0;
            end else if (inj_rvalid) begin
                obi_rsp.rvalid  = 1'b1;
                obi_rsp.r.rdata = 32'hDEAD_BEEF;
                inj_rvalid = 1'b0;
            end
            if (obi_req.req) begin
                if (stall >= gnt_delay) begin
                    obi_rsp.gnt = 1'b1;
                    stall = 0;
                    reads_seen++;
                    chk("rd_we", 32'(obi_req.a.we), 32'd0);
                    chk("rd_be", 32'(obi_req.a.be), 32'hF);
                    if (exp_addr.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_read: got addr 0x%08h expected no read", obi_req.a.addr);
                    end else begin
                        chk("rd_addr", obi_req.a.addr, exp_addr.pop_front());
                    end
                    if (!drop_rsp) begin
                        pend = 1;
                        paddr = obi_req.a.addr;
                    end
                end else begin
                    stall++;
                    req_wait = 1;
                    req_addr = obi_req.a.addr;
                end
            end
        end
    end

    // Pixel consumer: checks hold-while-stalled and pops the scoreboard on each handshake.
    initial begin : consumer
        bit stalled;
        logic [7:0] held;
        stalled = 0; held = '0;
        pixel_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stalled) begin
                chk("pix_valid_hold", 32'(pixel_valid), 32'd1);
                chk("pix_data_hold", 32'(pixel), 32'(held));
            end
            pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pixel_valid && pixel_ready) begin
                if (exp_pix.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pixel: got 0x%02h expected none", pixel);
                end else begin
                    chk("pixel", 32'(pixel), 32'(exp_pix.pop_front()));
                end
            end
            stalled = pixel_valid && !pixel_ready;
            held = pixel;
        end
    end

    initial begin : done_mon
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    end

    task automatic run_job(input int id, input job_t j);
        logic [31:0] a, word;
        int n, w;
        bit got_done;
        gnt_delay = j.gnt_delay; rand_ready = j.rand_ready; err_at = j.err_at;
        rd_idx = 0; reads_seen = 0; done_cnt = 0;
        a = {j.base[31:2], 2'b00}; n = j.len; w = 0;
        while (n > 0) begin
            exp_addr.push_back(a);
            if (w == j.err_at) break;
            word = mem_rd(a);
            for (int b = 0; b < 4 && n > 0; b++) begin
                exp_pix.push_back(word[8*b +: 8]);
                n--;
            end
            a = a + 32'd4;
            w++;
        end
        start = 1'b1; base = j.base; npix = LW'(j.len);
        @(posedge clk); #1;
        start = 1'b0; base = '0; npix = '0;
        chk($sformatf("job%0d_err_clear", id), 32'(err), 32'd0);
        chk($sformatf("job%0d_busy", id), 32'(busy), 32'd1);
        if (j.len == 0) chk($sformatf("job%0d_zero_done", id), 32'(done), 32'd1);
        else            chk($sformatf("job%0d_req_latency", id), 32'(obi_req.req), 32'd1);
        got_done = done;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            if (j.restart && c == 2) begin
                start = 1'b1; base = 32'h0000_9000; npix = LW'(2);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            got_done = done;
        end
        start = 1'b0; base = '0; npix = '0;
        if (!got_done) begin
            total++; bad++;
            $display("FAIL job%0d_timeout: got no done_o expected done_o within 3000 cycles", id);
            rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
            exp_pix.delete(); exp_addr.delete();
        end else begin
            chk($sformatf("job%0d_err", id), 32'(err), 32'(j.exp_err));
            chk($sformatf("job%0d_pix_left", id), 32'(exp_pix.size()), 32'd0);
            chk($sformatf("job%0d_rd_left", id), 32'(exp_addr.size()), 32'd0);
            chk($sformatf("job%0d_reads", id), 32'(reads_seen), 32'(j.exp_reads));
            @(posedge clk); #1;
            chk($sformatf("job%0d_done_low", id), 32'(done), 32'd0);
            chk($sformatf("job%0d_idle", id), 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("job%0d_done_pulses", id), 32'(done_cnt), 32'd1);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1);
    end

    initial begin : main
        //            base          len dly rnd err  rst reads err
        jobs[0] = '{32'h0000_1000,  8,  0,  0,  -1,  0,  2,   0};
        jobs[1] = '{32'h0000_2003,  5,  0,  0,  -1,  0,  2,   0};
        jobs[2] = '{32'h0000_3000,  0,  0,  0,  -1,  0,  0,   0};
        jobs[3] = '{32'h0000_4000, 12,  3,  1,  -1,  0,  3,   0};
        jobs[4] = '{32'h0000_1000,  8,  0,  0,   1,  0,  2,   1};
        jobs[5] = '{32'h0000_5000,  3,  1,  0,  -1,  1,  1,   0};
        jobs[6] = '{32'hFFFF_FFFC,  6,  0,  1,  -1,  0,  2,   0};
        jobs[7] = '{32'h0000_0101,  1,  2,  0,  -1,  0,  1,   0};
        jobs[8] = '{32'h0000_1000,  4,  0,  0,   0,  0,  1,   1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(obi_req.req), 32'd0);
        chk("rst_pix_valid", 32'(pixel_valid), 32'd0);
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_job(i, jobs[i]);

        // Reset while a read is outstanding; the late response must be ignored.
        gnt_delay = 0; rand_ready = 0; err_at = -1; drop_rsp = 1'b1; reads_seen = 0;
        exp_addr.push_back(32'h0000_6000);
        start = 1'b1; base = 32'h0000_6000; npix = LW'(4);
        @(posedge clk); #1;
        start = 1'b0; base = '0; npix = '0;
        for (int c = 0; c < 20 && reads_seen == 0; c++) begin
            @(posedge clk); #1;
        end
        chk("rstjob_granted", 32'(reads_seen), 32'd1);
        @(posedge clk); #1;
        chk("rstjob_wait_busy", 32'(busy), 32'd1);
        chk("rstjob_wait_noreq", 32'(obi_req.req), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstjob_busy", 32'(busy), 32'd0);
        chk("rstjob_req", 32'(obi_req.req), 32'd0);
        chk("rstjob_pix_valid", 32'(pixel_valid), 32'd0);
        chk("rstjob_pixel", 32'(pixel), 32'd0);
        chk("rstjob_done", 32'(done), 32'd0);
        inj_rvalid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("rstjob_late_rvalid", 32'({busy, pixel_valid, obi_req.req}), 32'd0);
        end
        drop_rsp = 1'b0;

        run_job(9, jobs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
